// File: rtl/softmax_write_ctrl.sv
// softmax_write_ctrl: streams a softmax result frame as valid/ready beats; define SOFTMAX_WR_ARGMAX_EN to add the argmax tracker
module softmax_write_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int OUTPUT_SIZE = 10,
  parameter int LANES = 1,
  localparam int SEL_WIDTH = $clog2(OUTPUT_SIZE + LANES + 1),
  localparam int BEATS = (OUTPUT_SIZE + LANES - 1) / LANES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          start_err,
  output logic [SEL_WIDTH-1:0]          sel_data,
  input  logic [LANES*DATA_WIDTH-1:0]   bank_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_keep,
  output logic                          out_last,
`ifdef SOFTMAX_WR_ARGMAX_EN
  output logic [SEL_WIDTH-1:0]          argmax_idx,
  output logic                          argmax_valid,
`endif
  output logic                          done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'((BEATS - 1) * LANES);
  state_t state, state_nxt;
  logic xfer, load, accept, last_nxt;
  logic [SEL_WIDTH-1:0] sel_nxt;
  logic [LANES-1:0] keep_nxt;
  logic [LANES*DATA_WIDTH-1:0] data_nxt;
  assign xfer = out_valid & out_ready;
  assign accept = (state == IDLE) & start;
  assign load = (state == FETCH) | ((state == SEND) & xfer & ~out_last);
  assign sel_nxt = sel_data + SEL_WIDTH'(LANES);
  assign last_nxt = sel_data >= LAST_SEL;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // Next beat as seen through the bank: lanes past the frame end are masked to zero
  always_comb begin
    keep_nxt = '0;
    data_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_nxt[i] = (sel_data + SEL_WIDTH'(i)) < SEL_WIDTH'(OUTPUT_SIZE);
      data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = keep_nxt[i] ? bank_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end
  // Frame sequencing: fetch primes the output register, send streams until the last beat leaves
  always_comb begin
    state_nxt = state == IDLE  ? (start ? FETCH : IDLE) :
                state == FETCH ? SEND :
                state == SEND  ? ((xfer & out_last) ? DONE : SEND) : IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Beat register and fetch address; holds steady while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_data <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      out_valid <= 1'b0;
      start_err <= 1'b0;
    end else begin
      start_err <= start & (state != IDLE);
      if (accept) sel_data <= '0;
      if (load) begin
        out_data <= data_nxt;
        out_keep <= keep_nxt;
        out_last <= last_nxt;
        sel_data <= sel_nxt;
        out_valid <= 1'b1;
      end else if (xfer) out_valid <= 1'b0;
    end
  end
`ifdef SOFTMAX_WR_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_val, cand_val;
  logic [SEL_WIDTH-1:0] max_idx, cand_idx, base;
  // Fold the beat on the output into the running maximum; strict compare keeps the lowest index on ties
  always_comb begin
    cand_val = max_val;
    cand_idx = max_idx;
    base = sel_data - SEL_WIDTH'(LANES);
    for (int i = 0; i < LANES; i++)
      if (out_keep[i] && out_data[i*DATA_WIDTH +: DATA_WIDTH] > cand_val) begin
        cand_val = out_data[i*DATA_WIDTH +: DATA_WIDTH];
        cand_idx = base + SEL_WIDTH'(i);
      end
  end
  // Tracker state and result publication as the final beat transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
      argmax_idx <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= xfer & out_last;
      if (accept) begin
        max_val <= '0;
        max_idx <= '0;
      end else if (xfer) begin
        max_val <= cand_val;
        max_idx <= cand_idx;
      end
      if (xfer & out_last) argmax_idx <= cand_idx;
    end
  end
`endif
endmodule

// File: tb/tb_softmax_write_ctrl.sv
// tb_softmax_write_ctrl: scoreboard bench for LANES=1 and LANES=4 writers (argmax checked when SOFTMAX_WR_ARGMAX_EN is defined)
`timescale 1ns/1ps
module tb_softmax_write_ctrl;
  localparam int DW = 24;
  localparam int OS = 10;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start1 = 0, start4 = 0, rdy1 = 0, rdy4 = 0;
  logic [3:0] sel1, sel4;
  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] mem4 [16];
  logic [DW-1:0] bd1, data1;
  logic [4*DW-1:0] bd4, data4;
  logic busy1, busy4, err1, err4, v1, v4, last1, last4, done1, done4, keep1;
  logic [3:0] keep4;
`ifdef SOFTMAX_WR_ARGMAX_EN
  logic [3:0] ami1, ami4;
  logic amv1, amv4;
`endif
  int checks = 0, errors = 0, xfer1 = 0, xfer4 = 0;
  logic [127:0] q1 [$];
  logic [127:0] q4 [$];
  logic [127:0] hold1, hold4;
  logic stall1 = 0, stall4 = 0;
  assign bd1 = mem1[sel1];
  always_comb begin
    bd4 = '0;
    for (int i = 0; i < 4; i++) bd4[i*DW +: DW] = mem4[sel4 + 4'(i)];
  end
  softmax_write_ctrl #(.DATA_WIDTH(DW), .OUTPUT_SIZE(OS), .LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .start_err(err1), .sel_data(sel1),
    .bank_data(bd1), .out_valid(v1), .out_ready(rdy1), .out_data(data1), .out_keep(keep1),
    .out_last(last1),
`ifdef SOFTMAX_WR_ARGMAX_EN
    .argmax_idx(ami1), .argmax_valid(amv1),
`endif
    .done(done1));
  softmax_write_ctrl #(.DATA_WIDTH(DW), .OUTPUT_SIZE(OS), .LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .start_err(err4), .sel_data(sel4),
    .bank_data(bd4), .out_valid(v4), .out_ready(rdy4), .out_data(data4), .out_keep(keep4),
    .out_last(last4),
`ifdef SOFTMAX_WR_ARGMAX_EN
    .argmax_idx(ami4), .argmax_valid(amv4),
`endif
    .done(done4));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pack(input int l, input logic [95:0] d, input logic [3:0] k, input logic la);
    return 128'(d) | (128'(k) << (DW * l)) | (128'(la) << (DW * l + l));
  endfunction
  function automatic logic [3:0] am_exp(input int d);
    logic [DW-1:0] best = '0;
    logic [3:0] idx = '0;
    for (int e = 0; e < OS; e++)
      if ((d == 1 ? mem1[e] : mem4[e]) > best) begin
        best = d == 1 ? mem1[e] : mem4[e];
        idx = 4'(e);
      end
    return idx;
  endfunction
  task automatic push_frame(input int d);
    int l, beats, idx;
    logic [95:0] dat;
    logic [3:0] k;
    l = d == 1 ? 1 : 4;
    beats = (OS + l - 1) / l;
    for (int b = 0; b < beats; b++) begin
      dat = '0;
      k = '0;
      for (int i = 0; i < l; i++) begin
        idx = b * l + i;
        if (idx < OS) begin
          k[i] = 1'b1;
          dat[i*DW +: DW] = d == 1 ? mem1[idx] : mem4[idx];
        end
      end
      if (d == 1) q1.push_back(pack(l, dat, k, b == beats - 1));
      else q4.push_back(pack(l, dat, k, b == beats - 1));
    end
  endtask
  task automatic frame(input int d, input int mode, input bit err);
    int beats, nbusy, cyc;
    bit fin;
    logic b, dn, v, se, ar;
    beats = d == 1 ? OS : (OS + 3) / 4;
    nbusy = 0;
    cyc = 0;
    fin = 0;
    push_frame(d);
    while (!fin) begin
      @(posedge clk);
      #1;
      ar = mode == 0 ? 1'b1 : ($urandom_range(3) == 0 ? 1'b0 : 1'(cyc % 2));
      if (d == 1) begin rdy1 = ar; start1 = (cyc == 0) || (err && cyc == 3); end
      else begin rdy4 = ar; start4 = (cyc == 0) || (err && cyc == 3); end
      @(negedge clk);
      b = d == 1 ? busy1 : busy4;
      dn = d == 1 ? done1 : done4;
      v = d == 1 ? v1 : v4;
      se = d == 1 ? err1 : err4;
      if (cyc == 0) begin
        check("idle_busy", b, 0);
        check("idle_done", dn, 0);
      end
      if (cyc == 1) check("fetch_valid", v, 0);
      if (cyc == 2) check("first_valid", v, 1);
      check("start_err", se, err && cyc == 4);
      nbusy += b;
      if (dn && cyc > 0) begin
        fin = 1;
        check("drained", d == 1 ? q1.size() : q4.size(), 0);
        if (mode == 0) begin
          check("done_at", cyc, beats + 2);
          check("busy_len", nbusy, beats + 2);
        end
`ifdef SOFTMAX_WR_ARGMAX_EN
        check("am_valid", d == 1 ? amv1 : amv4, 1);
        check("am_idx", d == 1 ? ami1 : ami4, am_exp(d));
`endif
      end
      if (cyc > 300) begin
        check("timeout", cyc, 0);
        fin = 1;
      end
      cyc++;
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) stall1 = 0;
    else begin
      if (stall1) check("u1_hold", {v1, last1, keep1, data1}, hold1);
      if (v1 && rdy1) begin
        check("u1_queued", q1.size() > 0, 1);
        if (q1.size() > 0) check("u1_beat", pack(1, 96'(data1), 4'(keep1), last1), q1.pop_front());
        xfer1++;
      end
      stall1 = v1 && !rdy1;
      hold1 = {v1, last1, keep1, data1};
    end
  end
  always @(negedge clk) begin
    if (!rst_n) stall4 = 0;
    else begin
      if (stall4) check("u4_hold", {v4, last4, keep4, data4}, hold4);
      if (v4 && rdy4) begin
        check("u4_queued", q4.size() > 0, 1);
        if (q4.size() > 0) check("u4_beat", pack(4, data4, keep4, last4), q4.pop_front());
        xfer4++;
      end
      stall4 = v4 && !rdy4;
      hold4 = {v4, last4, keep4, data4};
    end
  end
  initial begin
    int x0, n;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = DW'($urandom);
      mem4[i] = DW'($urandom);
    end
    #12 rst_n = 1;
    @(negedge clk);
    check("rst_valid", {v1, v4}, 0);
    check("rst_busy", {busy1, busy4}, 0);
    check("rst_sel", {sel1, sel4}, 0);
    check("rst_data", {data1, data4}, 0);
    check("rst_flags", {keep1, keep4, last1, last4, done1, done4, err1, err4}, 0);
    frame(1, 0, 0);
    frame(4, 0, 0);
    for (int i = 0; i < 16; i++) mem1[i] = DW'($urandom);
    frame(1, 1, 0);
    frame(1, 1, 0);
    frame(4, 1, 0);
    frame(4, 0, 1);
    frame(4, 0, 0);
    frame(1, 0, 1);
    push_frame(1);
    x0 = xfer1;
    @(posedge clk);
    #1 rdy1 = 1;
    start1 = 1;
    @(posedge clk);
    #1 start1 = 0;
    n = 0;
    while (xfer1 - x0 < 4 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("rst_reach", xfer1 - x0, 4);
    #2 rst_n = 0;
    #1;
    check("arst_valid", v1, 0);
    check("arst_busy", busy1, 0);
    check("arst_sel", sel1, 0);
    check("arst_data", data1, 0);
    check("arst_flags", {keep1, last1, done1, err1}, 0);
    q1.delete();
    @(posedge clk);
    #2 rst_n = 1;
    frame(1, 0, 0);
    for (int i = 0; i < 16; i++) mem1[i] = '0;
    mem1[0] = 3; mem1[1] = 9; mem1[2] = 2; mem1[3] = 9; mem1[4] = 1;
    frame(1, 1, 0);
    for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom_range(7));
    frame(4, 0, 0);
    mem4[9] = DW'(24'hffffff);
    frame(4, 1, 0);
    @(negedge clk);
    check("end_busy", {busy1, busy4}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
